// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller.
//   DEF_N_FLOORS : default floor count. The one-hot helpers below are sized to it,
//                  so a different floor count is set here, not by overriding the
//                  parameter on one instance.
//   dir_e        : sweep direction (DIR_UP / DIR_DOWN).
//   floor_t      : one-hot floor vector, bit 0 = lowest floor.
//   Helpers      : above_mask, below_mask, lowest_set, highest_set, is_onehot.
package elevator_pkg;

   localparam int DEF_N_FLOORS = 3;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   typedef logic [DEF_N_FLOORS-1:0] floor_t;

   // Floors strictly above the (one-hot) floor f.
   function automatic floor_t above_mask(input floor_t f);
      floor_t m;
      logic   seen;
      m    = '0;
      seen = 1'b0;
      for (int i = 0; i < DEF_N_FLOORS; i++) begin
         m[i] = seen;
         if (f[i]) seen = 1'b1;
      end
      return m;
   endfunction

   // Floors strictly below the (one-hot) floor f.
   function automatic floor_t below_mask(input floor_t f);
      floor_t m;
      logic   seen;
      m    = '0;
      seen = 1'b0;
      for (int i = DEF_N_FLOORS - 1; i >= 0; i--) begin
         m[i] = seen;
         if (f[i]) seen = 1'b1;
      end
      return m;
   endfunction

   function automatic floor_t lowest_set(input floor_t v);
      return v & (~v + 1'b1);
   endfunction

   function automatic floor_t highest_set(input floor_t v);
      floor_t r;
      r = '0;
      for (int i = 0; i < DEF_N_FLOORS; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic is_onehot(input floor_t v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Conditions one raw active-low button.
//   clk_50      : clock
//   rst_n       : async active-low reset
//   button_n    : raw button, 1 = released, asynchronous to clk_50
//   press_pulse : one-cycle strobe when a debounced press (1->0) is accepted
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic button_n,
   output logic press_pulse
);

   // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle,
   // so the compare is against the count already held, not the incremented one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic             deb_d_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_d_q     <= 1'b1;
         cnt_q       <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync1_q     <= button_n;
         sync2_q     <= sync1_q;
         deb_d_q     <= deb_q;
         press_pulse <= deb_d_q & ~deb_q;
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/call_request_latch.sv
// Button conditioning, per-floor call latch and SCAN target selection.
//   clk_50        : clock
//   rst_n         : async active-low reset
//   button_n      : raw call buttons, active-low
//   sos_mode      : emergency mode; clears and blocks all calls
//   floor_onehot  : current cabin floor, all-zero between floors
//   door_open     : cabin door open
//   moving        : cabin in motion
//   press_pulse   : one-cycle strobe per accepted press
//   req           : pending calls (LEDs)
//   target_valid  : a target is selected
//   target_onehot : selected destination floor
//   dir_up        : sweep direction, 1 = up
module call_request_latch
   import elevator_pkg::*;
#(
   parameter int N_FLOORS        = DEF_N_FLOORS,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic                clk_50,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] button_n,
   input  logic                sos_mode,
   input  logic [N_FLOORS-1:0] floor_onehot,
   input  logic                door_open,
   input  logic                moving,
   output logic [N_FLOORS-1:0] press_pulse,
   output logic [N_FLOORS-1:0] req,
   output logic                target_valid,
   output logic [N_FLOORS-1:0] target_onehot,
   output logic                dir_up
);

   genvar gi;
   generate
      for (gi = 0; gi < N_FLOORS; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_btn (
            .clk_50      (clk_50),
            .rst_n       (rst_n),
            .button_n    (button_n[gi]),
            .press_pulse (press_pulse[gi])
         );
      end
   endgenerate

   // Clear beats set, so a press at the floor being served is absorbed.
   logic [N_FLOORS-1:0] clr;
   assign clr = floor_onehot & {N_FLOORS{door_open & ~moving}};

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         req <= '0;
      end else if (sos_mode) begin
         req <= '0;
      end else begin
         req <= (req | press_pulse) & ~clr;
      end
   end

   dir_e                dir_q;
   dir_e                dir_n;
   logic                tv_n;
   logic [N_FLOORS-1:0] tgt_n;
   floor_t              above_req;
   floor_t              below_req;

   always_comb begin
      tv_n      = target_valid;
      tgt_n     = target_onehot;
      dir_n     = dir_q;
      above_req = req & above_mask(floor_onehot);
      below_req = req & below_mask(floor_onehot);
      if (req == '0) begin
         tv_n  = 1'b0;
         tgt_n = '0;
      end else if (is_onehot(floor_onehot)) begin
         // Between floors (or a corrupt floor code) leaves everything held.
         tv_n = 1'b1;
         if ((req & floor_onehot) != '0) begin
            tgt_n = floor_onehot;
         end else if (dir_q == DIR_UP) begin
            if (above_req != '0) begin
               tgt_n = lowest_set(above_req);
            end else begin
               tgt_n = highest_set(below_req);
               dir_n = DIR_DOWN;
            end
         end else begin
            if (below_req != '0) begin
               tgt_n = highest_set(below_req);
            end else begin
               tgt_n = lowest_set(above_req);
               dir_n = DIR_UP;
            end
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         target_valid  <= 1'b0;
         target_onehot <= '0;
         dir_q         <= DIR_UP;
      end else begin
         target_valid  <= tv_n;
         target_onehot <= tgt_n;
         dir_q         <= dir_n;
      end
   end

   assign dir_up = (dir_q == DIR_UP);

   a_floor_code : assert property (@(posedge clk_50) disable iff (!rst_n)
      (floor_onehot == '0) || is_onehot(floor_onehot));

endmodule

// File: tb/tb_call_request_latch.sv
module tb_call_request_latch;

   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic [2:0] button_n;
   logic       sos_mode;
   logic [2:0] floor_onehot;
   logic       door_open;
   logic       moving;
   logic [2:0] press_pulse;
   logic [2:0] req;
   logic       target_valid;
   logic [2:0] target_onehot;
   logic       dir_up;

   int checks   = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int base;

   always #5 clk_50 = ~clk_50;

   call_request_latch #(
      .N_FLOORS        (3),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk_50        (clk_50),
      .rst_n         (rst_n),
      .button_n      (button_n),
      .sos_mode      (sos_mode),
      .floor_onehot  (floor_onehot),
      .door_open     (door_open),
      .moving        (moving),
      .press_pulse   (press_pulse),
      .req           (req),
      .target_valid  (target_valid),
      .target_onehot (target_onehot),
      .dir_up        (dir_up)
   );

   always @(negedge clk_50) begin
      if (press_pulse != 3'b000) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic press(input int idx);
      button_n[idx] = 1'b0;
      repeat (8) tick();
      button_n[idx] = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      rst_n        = 1'b0;
      button_n     = 3'b111;
      sos_mode     = 1'b0;
      floor_onehot = 3'b001;
      door_open    = 1'b0;
      moving       = 1'b0;
      #22;
      check_val("rst_pulse", press_pulse, 3'b000);
      check_val("rst_req", req, 3'b000);
      check_val("rst_tv", target_valid, 1'b0);
      check_val("rst_tgt", target_onehot, 3'b000);
      check_val("rst_dir", dir_up, 1'b1);
      rst_n = 1'b1;
      tick();

      // idle
      base = pulse_cnt;
      repeat (50) tick();
      check_val("idle_pulses", pulse_cnt - base, 0);
      check_val("idle_req", req, 3'b000);
      check_val("idle_dir", dir_up, 1'b1);
      check_val("idle_tv", target_valid, 1'b0);

      // glitch shorter than the debounce window
      base = pulse_cnt;
      button_n[2] = 1'b0;
      repeat (3) tick();
      button_n[2] = 1'b1;
      repeat (12) tick();
      check_val("short_pulses", pulse_cnt - base, 0);
      check_val("short_req", req, 3'b000);

      // accepted press with edge-exact latency
      base = pulse_cnt;
      button_n[2] = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (e == 5) check_val("lat_e5_pulse", press_pulse, 3'b000);
         if (e == 6) begin
            check_val("lat_e6_pulse", press_pulse, 3'b100);
            check_val("lat_e6_req", req, 3'b000);
         end
         if (e == 7) begin
            check_val("lat_e7_pulse", press_pulse, 3'b000);
            check_val("lat_e7_req", req, 3'b100);
         end
      end
      button_n[2] = 1'b1;
      repeat (10) tick();
      check_val("hold_one_pulse", pulse_cnt - base, 1);
      check_val("led_persist", req, 3'b100);
      check_val("tgt_up_100", target_onehot, 3'b100);
      check_val("tv_after_press", target_valid, 1'b1);

      // call at current floor wins, then is served
      press(0);
      check_val("req_101", req, 3'b101);
      check_val("tgt_cur_floor", target_onehot, 3'b001);
      check_val("dir_cur_floor", dir_up, 1'b1);
      door_open = 1'b1;
      tick();
      check_val("served_req", req, 3'b100);
      tick();
      check_val("served_tgt", target_onehot, 3'b100);
      check_val("served_dir", dir_up, 1'b1);
      door_open = 1'b0;

      // top floor reversal
      floor_onehot = 3'b100;
      repeat (2) tick();
      check_val("top_tgt_here", target_onehot, 3'b100);
      press(0);
      check_val("top_req_101", req, 3'b101);
      door_open = 1'b1;
      tick();
      check_val("top_req_001", req, 3'b001);
      check_val("top_dir_before", dir_up, 1'b1);
      tick();
      check_val("top_dir_rev", dir_up, 1'b0);
      check_val("top_tgt_rev", target_onehot, 3'b001);
      check_val("top_tv_rev", target_valid, 1'b1);
      door_open = 1'b0;

      // downward sweep picks nearest below, then SOS
      press(1);
      check_val("dn_req_011", req, 3'b011);
      check_val("dn_tgt_010", target_onehot, 3'b010);
      sos_mode = 1'b1;
      tick();
      check_val("sos_req_clr", req, 3'b000);
      tick();
      check_val("sos_tv", target_valid, 1'b0);
      check_val("sos_tgt", target_onehot, 3'b000);
      check_val("sos_dir_hold", dir_up, 1'b0);
      press(2);
      check_val("sos_press_ign", req, 3'b000);
      sos_mode = 1'b0;
      repeat (5) tick();
      check_val("sos_exit_req", req, 3'b000);
      press(1);
      check_val("post_sos_req", req, 3'b010);
      check_val("post_sos_tgt", target_onehot, 3'b010);

      // between floors: target held, new call still latched
      floor_onehot = 3'b000;
      press(0);
      check_val("mid_req", req, 3'b011);
      check_val("mid_tgt_hold", target_onehot, 3'b010);
      check_val("mid_tv_hold", target_valid, 1'b1);
      check_val("mid_dir_hold", dir_up, 1'b0);

      // serve floor 2, leaving req=001
      floor_onehot = 3'b010;
      door_open = 1'b1;
      repeat (2) tick();
      door_open = 1'b0;
      check_val("pre_rst_req", req, 3'b001);
      check_val("pre_rst_tgt", target_onehot, 3'b001);

      // async reset in the middle of a debounce
      base = pulse_cnt;
      button_n[1] = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_req", req, 3'b000);
      check_val("arst_tv", target_valid, 1'b0);
      check_val("arst_tgt", target_onehot, 3'b000);
      check_val("arst_dir", dir_up, 1'b1);
      check_val("arst_pulse", press_pulse, 3'b000);
      button_n[1] = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (15) tick();
      check_val("arst_no_stale", pulse_cnt - base, 0);
      check_val("arst_req_after", req, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
